multicycle_control: RTL and testbench

Multi-cycle control unit for the 16-bit processor. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the datapath enables and memory strobes. Selects the immediate-generator mode (sign-extend, shift-by-1, shift-by-8) that `imm_gen_component` applies to the current instruction.

---
 rtl/multicycle_control.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing FETCH/DECODE/EXEC/MEM/WB for the 16-bit core.
// Optional retire counter under MC_RETIRE_COUNT_EN.
//
// Ports:
//   clock, reset        sync active-high reset
//   inst[15:0]          instruction word (opcode in low bits)
//   mem_ready           memory access completes when high under a strobe
//   alu_zero            ALU zero flag for BEQ
//   pc_write, pc_src    PC load enable and source select
//   ir_write            IR/opcode latch enable
//   mem_read, mem_write memory strobes
//   reg_write           register file write enable
//   alu_src, mem_to_reg datapath muxes
//   imm_sel             immediate-generator mode
//   illegal, halted     status
//   state               current state, for debug
//   retired             completed-instruction count (MC_RETIRE_COUNT_EN only)
module multicycle_control #(
  parameter int OPCODE_W = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] inst,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic [1:0]  imm_sel,
  output logic        illegal,
  output logic        halted,
  output logic [2:0]  state
`ifdef MC_RETIRE_COUNT_EN
  ,
  output logic [15:0] retired
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef logic [OPCODE_W-1:0] op_t;

  localparam op_t OP_R     = OPCODE_W'(0);
  localparam op_t OP_I     = OPCODE_W'(1);
  localparam op_t OP_LOAD  = OPCODE_W'(2);
  localparam op_t OP_STORE = OPCODE_W'(3);
  localparam op_t OP_BEQ   = OPCODE_W'(4);
  localparam op_t OP_JUMP  = OPCODE_W'(5);
  localparam op_t OP_LUI   = OPCODE_W'(6);
  localparam op_t OP_HALT  = OPCODE_W'(15);

  state_t state_q;
  state_t state_d;
  op_t    op_q;
  logic   legal;
  logic   is_load;

  logic unused_inst;
  assign unused_inst = ^inst[15:OPCODE_W];

  assign is_load = (op_q == OP_LOAD);

  always_comb begin
    legal = 1'b0;
    case (op_q)
      OP_R, OP_I, OP_LOAD, OP_STORE,
      OP_BEQ, OP_JUMP, OP_LUI, OP_HALT: legal = 1'b1;
      default:                          legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ir_write)
        op_q <= inst[OPCODE_W-1:0];
    end
  end

  // All outputs are forced low while reset is high, even before
  // the first edge has put the register into a known state.
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    imm_sel    = 2'b00;
    illegal    = 1'b0;
    halted     = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = DECODE;
          end
        end
        DECODE: begin
          if (op_q == OP_HALT) begin
            state_d = HALT;
          end else if (!legal) begin
            illegal = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          case (op_q)
            OP_R: begin
              alu_src = 1'b0;
              state_d = WB;
            end
            OP_I: begin
              alu_src = 1'b1;
              state_d = WB;
            end
            OP_LOAD, OP_STORE: begin
              alu_src = 1'b1;
              state_d = MEM;
            end
            OP_BEQ: begin
              imm_sel = 2'b01;
              if (alu_zero) begin
                pc_write = 1'b1;
                pc_src   = 2'b01;
              end
              state_d = FETCH;
            end
            OP_JUMP: begin
              imm_sel  = 2'b01;
              pc_write = 1'b1;
              pc_src   = 2'b10;
              state_d  = FETCH;
            end
            OP_LUI: begin
              alu_src = 1'b1;
              imm_sel = 2'b10;
              state_d = WB;
            end
            default: state_d = FETCH;
          endcase
        end
        MEM: begin
          mem_read  = is_load;
          mem_write = !is_load;
          if (mem_ready)
            state_d = is_load ? WB : FETCH;
        end
        WB: begin
          reg_write  = 1'b1;
          mem_to_reg = is_load;
          state_d    = FETCH;
        end
        HALT: begin
          halted = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign state = reset ? 3'd0 : state_q;

`ifdef MC_RETIRE_COUNT_EN
  logic [15:0] count_q;
  logic        retire;

  assign retire = (state_d == FETCH) &&
                  ((state_q == EXEC) ||
                   (state_q == MEM)  ||
                   (state_q == WB));

  always_ff @(posedge clock) begin
    if (reset)
      count_q <= '0;
    else if (retire)
      count_q <= count_q + 16'd1;
  end

  assign retired = reset ? 16'd0 : count_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed + random instructions checked
// against a phase-list reference model built from per-opcode CPI.
module tb_multicycle_control;

  logic        clock;
  logic        reset;
  logic [15:0] inst;
  logic        mem_ready;
  logic        alu_zero;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        alu_src;
  logic        mem_to_reg;
  logic [1:0]  imm_sel;
  logic        illegal;
  logic        halted;
  logic [2:0]  state;
`ifdef MC_RETIRE_COUNT_EN
  logic [15:0] retired;
  int          rcount = 0;
`endif

  int passed = 0;
  int total  = 0;

  multicycle_control #(.OPCODE_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .inst       (inst),
    .mem_ready  (mem_ready),
    .alu_zero   (alu_zero),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .imm_sel    (imm_sel),
    .illegal    (illegal),
    .halted     (halted),
    .state      (state)
`ifdef MC_RETIRE_COUNT_EN
    ,
    .retired    (retired)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected outputs for one cycle, from the phase the instruction
  // is in (0 F,1 D,2 E,3 M,4 W,5 H) and its opcode.
  function automatic logic [15:0] model(input int ph,
                                        input logic [3:0] op,
                                        input logic mr,
                                        input logic az);
    logic pw, irw, rd, wr, rgw, as, m2r, il, hl;
    logic [1:0] ps, is;
    pw = 0; irw = 0; rd = 0; wr = 0; rgw = 0;
    as = 0; m2r = 0; il = 0; hl = 0; ps = 0; is = 0;
    case (ph)
      0: begin
        rd = 1;
        if (mr) begin irw = 1; pw = 1; end
      end
      1: il = !((op <= 4'd6) || (op == 4'd15));
      2: case (op)
        4'd1, 4'd2, 4'd3: as = 1;
        4'd4: begin
          is = 2'b01;
          if (az) begin pw = 1; ps = 2'b01; end
        end
        4'd5: begin is = 2'b01; pw = 1; ps = 2'b10; end
        4'd6: begin as = 1; is = 2'b10; end
        default: ;
      endcase
      3: if (op == 4'd2) rd = 1; else wr = 1;
      4: begin rgw = 1; m2r = (op == 4'd2); end
      5: hl = 1;
      default: ;
    endcase
    return {pw, ps, irw, rd, wr, rgw, as, m2r, is, il, hl, 3'(ph)};
  endfunction

  task automatic cyc(input int ph, input logic [3:0] op,
                     input logic [15:0] iw, input logic mr,
                     input logic az, input logic rst);
    logic [15:0] exp, got;
    inst = iw; mem_ready = mr; alu_zero = az; reset = rst;
    exp = rst ? 16'h0 : model(ph, op, mr, az);
    @(negedge clock);
    got = {pc_write, pc_src, ir_write, mem_read, mem_write,
           reg_write, alu_src, mem_to_reg, imm_sel, illegal,
           halted, state};
    total++;
    assert (got === exp) passed++;
    else $error("FAIL ph%0d op%0h rst%0b: got %h want %h",
                ph, op, rst, got, exp);
    @(posedge clock);
    #1;
  endtask

  // az: 0/1 forces alu_zero, anything else randomizes it per cycle.
  task automatic run_instr(input logic [15:0] w, input int fs,
                           input int ms, input int az);
    int q[$];
    logic [3:0] op;
    logic z;
    op = w[3:0];
    case (op)
      4'd0, 4'd1, 4'd6: q = '{0, 1, 2, 4};
      4'd2:             q = '{0, 1, 2, 3, 4};
      4'd3:             q = '{0, 1, 2, 3};
      4'd4, 4'd5:       q = '{0, 1, 2};
      4'd15: begin
        q = '{0, 1};
        repeat (12) q.push_back(5);
      end
      default:          q = '{0, 1};
    endcase
    foreach (q[k]) begin
      z = (az == 0 || az == 1) ? 1'(az) : 1'($urandom_range(0, 1));
      if (q[k] == 0 || q[k] == 3) begin
        repeat (q[k] == 0 ? fs : ms)
          cyc(q[k], op, 16'($urandom), 1'b0, z, 1'b0);
        cyc(q[k], op, w, 1'b1, z, 1'b0);
      end else begin
        cyc(q[k], op, 16'($urandom),
            1'($urandom_range(0, 1)), z, 1'b0);
      end
    end
`ifdef MC_RETIRE_COUNT_EN
    if (op <= 4'd6) rcount++;
    total++;
    assert (retired === 16'(rcount)) passed++;
    else $error("FAIL retired: got %0d want %0d", retired, rcount);
`endif
  endtask

  initial begin
    reset = 1'b1; inst = '0; mem_ready = 1'b1; alu_zero = 1'b0;
    repeat (3) cyc(0, 4'd0, 16'h0, 1'b1, 1'b0, 1'b1);

    run_instr(16'h1230, 0, 0, 0);
    run_instr(16'h0452, 0, 2, 0);
    run_instr(16'h0804, 0, 0, 1);
    run_instr(16'h0804, 0, 0, 0);
    run_instr(16'h4B06, 0, 0, 0);
    run_instr(16'h0007, 0, 0, 0);
    run_instr(16'h5A5B, 1, 0, 0);

    for (int n = 0; n < 40; n++)
      run_instr({12'($urandom), 4'($urandom_range(0, 14))},
                $urandom_range(0, 2), $urandom_range(0, 2), 2);

    // Reset arriving during a stalled STORE in MEM.
    cyc(0, 4'd3, 16'h0013, 1'b1, 1'b0, 1'b0);
    cyc(1, 4'd3, 16'h0, 1'b1, 1'b0, 1'b0);
    cyc(2, 4'd3, 16'h0, 1'b1, 1'b0, 1'b0);
    cyc(3, 4'd3, 16'h0, 1'b0, 1'b0, 1'b0);
    cyc(3, 4'd3, 16'h0, 1'b0, 1'b0, 1'b1);
    cyc(3, 4'd3, 16'h0, 1'b1, 1'b0, 1'b1);
`ifdef MC_RETIRE_COUNT_EN
    rcount = 0;
`endif
    run_instr(16'h2221, 0, 0, 2);

    run_instr(16'h000F, 0, 0, 2);
    cyc(5, 4'd15, 16'h0, 1'b1, 1'b0, 1'b1);
`ifdef MC_RETIRE_COUNT_EN
    rcount = 0;
`endif
    run_instr(16'h1230, 0, 0, 0);
    run_instr(16'h0452, 0, 0, 0);
    run_instr(16'h0013, 1, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
